// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-sequence generator and the pulse_capture receiver.
package pulse_pkg;

  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF    = 400000;
  localparam int unsigned GLITCH_CYC_DEF = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLow,
    StWaitP1,
    StP1High,
    StGap,
    StP2High,
    StWaitNext,
    StDone
  } cap_state_t;

  // States during which the capture watchdog runs.
  function automatic logic cap_watched(input cap_state_t s);
    return (s != StIdle) && (s != StDone);
  endfunction

  // States during which the sequence period accumulates.
  function automatic logic cap_in_period(input cap_state_t s);
    return (s == StP1High) || (s == StGap) || (s == StP2High) || (s == StWaitNext);
  endfunction

endpackage

// File: rtl/pulse_sync_filter.sv
// Two-flop synchronizer for pulse_in with an optional glitch filter,
// compiled in by PULSE_CAPTURE_GLITCH_FILTER_EN.
module pulse_sync_filter #(
  parameter int unsigned GLITCH_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic pin
);

  if (GLITCH_CYC == 0) begin : g_bad_cfg
    $error("pulse_sync_filter: GLITCH_CYC must be at least 1");
  end

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pulse_in;
      s2_q <= s1_q;
    end
  end

`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FiltW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(GLITCH_CYC - 1);

  logic             filt_q, filt_d;
  logic [FiltW-1:0] run_q, run_d;

  // run_q counts consecutive cycles the synchronized level differs from pin;
  // any return to the current level restarts the count.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (s2_q != filt_q) begin
      if (run_q == FiltLast) begin
        filt_d = s2_q;
      end else begin
        run_d = run_q + FiltW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign pin = filt_q;
`else
  assign pin = s2_q;
`endif

endmodule

// File: rtl/pulse_capture.sv
// Measures pulse-1 width, gap, pulse-2 width and period of a two-pulse sequence.
// Optional input glitch filter: PULSE_CAPTURE_GLITCH_FILTER_EN.
module pulse_capture
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned GLITCH_CYC = GLITCH_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             arm,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] width1,
  output logic [CNT_W-1:0] gap,
  output logic [CNT_W-1:0] width2,
  output logic [CNT_W-1:0] period,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] WdLimit = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  logic pin, pin_q;
  logic rise, fall, wd_hit;

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] w1_q, w1_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] w2_q, w2_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             to_q, to_d;

  pulse_sync_filter #(
    .GLITCH_CYC(GLITCH_CYC)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .pin     (pin)
  );

  assign rise   = pin & ~pin_q;
  assign fall   = ~pin & pin_q;
  assign wd_hit = (wd_q >= WdLimit);

  always_comb begin
    state_d = state_q;
    w1_d    = w1_q;
    gap_d   = gap_q;
    w2_d    = w2_q;
    per_d   = per_q;
    wd_d    = wd_q;
    to_d    = to_q;

    if (cap_watched(state_q)) begin
      wd_d = sat_inc(wd_q);
    end
    if (cap_in_period(state_q)) begin
      per_d = sat_inc(per_q);
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StWaitLow;
          w1_d    = '0;
          gap_d   = '0;
          w2_d    = '0;
          per_d   = '0;
          wd_d    = '0;
          to_d    = 1'b0;
        end
      end
      StWaitLow: begin
        if (!pin) begin
          state_d = StWaitP1;
        end
      end
      StWaitP1: begin
        // The edge cycle itself is the first counted cycle of width1 and period.
        if (rise) begin
          state_d = StP1High;
          w1_d    = CntOne;
          per_d   = CntOne;
        end
      end
      StP1High: begin
        if (fall) begin
          state_d = StGap;
          gap_d   = CntOne;
        end else begin
          w1_d = sat_inc(w1_q);
        end
      end
      StGap: begin
        if (rise) begin
          state_d = StP2High;
          w2_d    = CntOne;
        end else begin
          gap_d = sat_inc(gap_q);
        end
      end
      StP2High: begin
        if (fall) begin
          state_d = StWaitNext;
        end else begin
          w2_d = sat_inc(w2_q);
        end
      end
      StWaitNext: begin
        if (rise) begin
          state_d = StDone;
          per_d   = per_q;
        end
      end
      StDone: begin
        if (meas_ready) begin
          if (arm) begin
            state_d = StWaitLow;
            w1_d    = '0;
            gap_d   = '0;
            w2_d    = '0;
            per_d   = '0;
            wd_d    = '0;
            to_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog abort; a terminating edge in the same cycle still wins.
    if (cap_watched(state_q) && wd_hit && !((state_q == StWaitNext) && rise)) begin
      state_d = StDone;
      to_d    = 1'b1;
      per_d   = '0;
      unique case (state_q)
        StP1High: w1_d  = '0;
        StGap:    gap_d = '0;
        StP2High: w2_d  = '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pin_q   <= 1'b0;
      w1_q    <= '0;
      gap_q   <= '0;
      w2_q    <= '0;
      per_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin;
      w1_q    <= w1_d;
      gap_q   <= gap_d;
      w2_q    <= w2_d;
      per_q   <= per_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign meas_valid  = (state_q == StDone);
  assign width1      = w1_q;
  assign gap         = gap_q;
  assign width2      = w2_q;
  assign period      = per_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: a long-timeout instance for measurements and a
// TIMEOUT=500 instance for the watchdog case.
module tb_pulse_capture;

  localparam int unsigned CW = 32;
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n, pulse_in;
  logic          arm, meas_ready, busy, meas_valid, timeout_err;
  logic [CW-1:0] width1, gap, width2, period;
  logic          arm_wd, ready_wd, busy_wd, valid_wd, to_wd;
  logic [CW-1:0] w1_wd, gap_wd, w2_wd, per_wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_capture #(
    .CNT_W  (CW),
    .TIMEOUT(5000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .arm        (arm),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .width1     (width1),
    .gap        (gap),
    .width2     (width2),
    .period     (period),
    .timeout_err(timeout_err)
  );

  pulse_capture #(
    .CNT_W  (CW),
    .TIMEOUT(500)
  ) dut_wd (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .arm        (arm_wd),
    .busy       (busy_wd),
    .meas_valid (valid_wd),
    .meas_ready (ready_wd),
    .width1     (w1_wd),
    .gap        (gap_wd),
    .width2     (w2_wd),
    .period     (per_wd),
    .timeout_err(to_wd)
  );

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input int h1, input int l1, input int h2, input int l2);
    pulse_in = 1'b1; tick(h1);
    pulse_in = 1'b0; tick(l1);
    pulse_in = 1'b1; tick(h2);
    pulse_in = 1'b0; tick(l2);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!meas_valid && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, meas_valid}, 1);
  endtask

  task automatic chk_fields(input string tag, input int e1, input int eg, input int e2,
                            input int ep, input logic eto);
    chk({tag, "_width1"}, width1, e1);
    chk({tag, "_gap"}, gap, eg);
    chk({tag, "_width2"}, width2, e2);
    chk({tag, "_period"}, period, ep);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, eto});
  endtask

  task automatic accept(input string tag);
    meas_ready = 1'b1; tick(1); meas_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, meas_valid}, 0);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "hang");
  end

  initial begin
    rst_n = 1'b0; pulse_in = 1'b0; arm = 1'b0; meas_ready = 1'b0;
    arm_wd = 1'b0; ready_wd = 1'b0;
    tick(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, meas_valid}, 0);
    chk_fields("rst", 0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Watchdog: input held low, result exactly 501 cycles after arm.
    arm_wd = 1'b1; tick(1); arm_wd = 1'b0;
    chk("wd_busy", {31'd0, busy_wd}, 1);
    tick(500);
    chk("wd_valid_early", {31'd0, valid_wd}, 0);
    tick(1);
    chk("wd_valid", {31'd0, valid_wd}, 1);
    chk("wd_to", {31'd0, to_wd}, 1);
    chk("wd_fields", w1_wd | gap_wd | w2_wd | per_wd, 0);
    ready_wd = 1'b1; tick(1); ready_wd = 1'b0;
    chk("wd_valid_drop", {31'd0, valid_wd}, 0);

    // Basic sequence, with exact valid latency from the terminating edge.
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("s1_busy", {31'd0, busy}, 1);
    tick(5);
    send_seq(30, 200, 60, 710);
    pulse_in = 1'b1;
    tick(LAT);
    chk("s1_valid_early", {31'd0, meas_valid}, 0);
    tick(1);
    chk("s1_valid", {31'd0, meas_valid}, 1);
    chk_fields("s1", 30, 200, 60, 1000, 1'b0);
    pulse_in = 1'b0;
    accept("s1");
    tick(10);

    // Arm mid-pulse: that pulse is skipped.
    pulse_in = 1'b1; tick(10);
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(10);
    pulse_in = 1'b0; tick(100);
    send_seq(30, 200, 60, 710);
    pulse_in = 1'b1;
    wait_valid("s3", 20);
    pulse_in = 1'b0;
    chk_fields("s3", 30, 200, 60, 1000, 1'b0);

    // Pending result held through 50 cycles of back-pressure and an ignored arm.
    tick(20);
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(29);
    chk("s4_valid_held", {31'd0, meas_valid}, 1);
    chk("s4_busy_held", {31'd0, busy}, 1);
    chk_fields("s4", 30, 200, 60, 1000, 1'b0);
    meas_ready = 1'b1; arm = 1'b1; tick(1); meas_ready = 1'b0; arm = 1'b0;
    chk("s4_valid_drop", {31'd0, meas_valid}, 0);
    chk("s4_busy_rearm", {31'd0, busy}, 1);

    // Capture already re-armed: 1-cycle glitch before pulse 1.
    tick(5);
    pulse_in = 1'b1; tick(1);
    pulse_in = 1'b0; tick(20);
    send_seq(30, 200, 60, 710);
    pulse_in = 1'b1;
    wait_valid("s5", 20);
    pulse_in = 1'b0;
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
    chk_fields("s5", 30, 200, 60, 1000, 1'b0);
`else
    chk_fields("s5", 1, 20, 30, 251, 1'b0);
`endif
    accept("s5");
    tick(10);

    // Reset during GAP aborts the capture.
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(5);
    pulse_in = 1'b1; tick(30);
    pulse_in = 1'b0; tick(50);
    rst_n = 1'b0;
    #2;
    chk("s6_busy", {31'd0, busy}, 0);
    chk("s6_valid", {31'd0, meas_valid}, 0);
    chk_fields("s6", 0, 0, 0, 0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("s6_no_autostart", {31'd0, busy}, 0);
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(5);
    send_seq(30, 200, 60, 710);
    pulse_in = 1'b1;
    wait_valid("s6b", 20);
    pulse_in = 1'b0;
    chk_fields("s6b", 30, 200, 60, 1000, 1'b0);
    accept("s6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
